// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // An all-zero instruction word decodes as sll $0,$0,0, i.e. a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between MIPS stages, with optional two-entry
// skid buffer (registered in_ready), flush-to-bubble and a stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WIDTH-1:0] FILL = WIDTH'(NOP_INSTR);

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_data;
  logic             accept, consume;
  logic             load_main_in, load_main_skid;
  logic             clear;

  assign clear     = rst | flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = ST_FULL;
        end
      end
      ST_FULL: begin
        // accept without consume only happens with SKID=1; SKID=0 gates
        // in_ready on out_ready while full.
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d = ST_SKID;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (consume) begin
          load_main_skid = 1'b1;
          state_d        = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // NOTE: the data register is deliberately reset: a cleared stage must show a
  // NOP on out_data, not stale contents of a flushed instruction.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_EMPTY;
      main_q  <= FILL;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_data;
      end
    end
  end

  if (SKID != 0) begin : g_skid
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;

    always_ff @(posedge clk) begin
      if (clear) begin
        skid_q     <= FILL;
        in_ready_q <= 1'b1;
      end else begin
        if ((state_q == ST_FULL) && accept && !consume) begin
          skid_q <= in_data;
        end
        // Registered copy of (state != ST_SKID) for the upcoming cycle.
        in_ready_q <= (state_d != ST_SKID);
      end
    end

    assign skid_data = skid_q;
    assign in_ready  = in_ready_q;
  end else begin : g_no_skid
    assign skid_data = FILL;
    assign in_ready  = !out_valid || out_ready;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-style reference model for three instances
// (SKID=1, SKID=0, SKID=1 stall-counter soak) plus directed literal checks.
module tb_pipe_stage_reg;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        flush     [N];
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [31:0] in_data   [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [31:0] out_data  [N];
  logic [15:0] stall_cnt [N];

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .stall_cnt(stall_cnt[0])
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_no_skid (
    .clk(clk), .rst(rst[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .stall_cnt(stall_cnt[1])
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) u_sat (
    .clk(clk), .rst(rst[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .stall_cnt(stall_cnt[2])
  );

  int n_checks = 0;
  int n_errors = 0;
  bit sat_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit skid_of(input int id);
    return id != 1;
  endfunction

  // Reference model: the held bundles form a FIFO of capacity 2 (SKID=1) or
  // 1 (SKID=0); in_ready follows from occupancy; stalls counted saturating.
  logic [31:0] m_fifo [N][4];
  int          m_head  [N] = '{default: 0};
  int          m_cnt   [N] = '{default: 0};
  int          m_stall [N] = '{default: 0};

  always @(negedge clk) begin
    for (int id = 0; id < N; id++) begin
      bit ev, er, acc, con;
      ev = m_cnt[id] > 0;
      er = skid_of(id) ? (m_cnt[id] < 2) : (m_cnt[id] == 0 || out_ready[id] == 1'b1);
      check($sformatf("m%0d_out_valid", id), 32'(out_valid[id]), 32'(ev));
      check($sformatf("m%0d_in_ready", id), 32'(in_ready[id]), 32'(er));
      check($sformatf("m%0d_stall_cnt", id), 32'(stall_cnt[id]), 32'(m_stall[id]));
      if (ev) check($sformatf("m%0d_out_data", id), out_data[id], m_fifo[id][m_head[id]]);
      if (rst[id]) begin
        m_cnt[id]   = 0;
        m_head[id]  = 0;
        m_stall[id] = 0;
      end else begin
        if (ev && !out_ready[id] && m_stall[id] < 65535) m_stall[id]++;
        if (flush[id]) begin
          m_cnt[id] = 0;
        end else begin
          acc = in_valid[id] && er;
          con = ev && out_ready[id];
          if (con) begin
            m_head[id] = (m_head[id] + 1) % 4;
            m_cnt[id]--;
          end
          if (acc) begin
            m_fifo[id][(m_head[id] + m_cnt[id]) % 4] = in_data[id];
            m_cnt[id]++;
          end
        end
      end
    end
  end

  // Stall-counter soak on the third instance, concurrent with the main tests.
  initial begin
    rst[2] = 1'b1; flush[2] = 1'b0; in_valid[2] = 1'b0; out_ready[2] = 1'b0; in_data[2] = '0;
    step(); step();
    rst[2] = 1'b0;
    in_valid[2] = 1'b1; in_data[2] = 32'h0000_00AA;
    step();
    in_valid[2] = 1'b0;
    repeat (70000) step();
    check("sat_at_max", 32'(stall_cnt[2]), 32'd65535);
    check("sat_data_held", out_data[2], 32'h0000_00AA);
    repeat (5) step();
    check("sat_no_wrap", 32'(stall_cnt[2]), 32'd65535);
    flush[2] = 1'b1;
    step();
    flush[2] = 1'b0;
    check("sat_flush_keeps", 32'(stall_cnt[2]), 32'd65535);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    check("sat_rst_clears", 32'(stall_cnt[2]), 32'd0);
    in_valid[2] = 1'b1; in_data[2] = 32'h0000_00BB;
    step();
    in_valid[2] = 1'b0;
    repeat (10) step();
    check("sat_count_10", 32'(stall_cnt[2]), 32'd10);
    flush[2] = 1'b1; out_ready[2] = 1'b1;
    step();
    flush[2] = 1'b0; out_ready[2] = 1'b0;
    check("sat_flush_mid", 32'(stall_cnt[2]), 32'd10);
    check("sat_flush_empty", 32'(out_valid[2]), 32'd0);
    repeat (3) step();
    check("sat_idle_hold", 32'(stall_cnt[2]), 32'd10);
    sat_done = 1'b1;
  end

  initial begin
    int seq [2];
    seq = '{32'h1000_0000, 32'h2000_0000};
    for (int id = 0; id < 2; id++) begin
      rst[id] = 1'b1; flush[id] = 1'b0; in_valid[id] = 1'b0;
      out_ready[id] = 1'b0; in_data[id] = '0;
    end
    step(); step();
    for (int id = 0; id < 2; id++) rst[id] = 1'b0;
    for (int id = 0; id < 2; id++) begin
      check($sformatf("rst%0d_out_valid", id), 32'(out_valid[id]), 32'd0);
      check($sformatf("rst%0d_out_data", id), out_data[id], 32'd0);
      check($sformatf("rst%0d_stall", id), 32'(stall_cnt[id]), 32'd0);
      check($sformatf("rst%0d_in_ready", id), 32'(in_ready[id]), 32'd1);
    end

    // First bundle after reset, both modes.
    for (int id = 0; id < 2; id++) begin
      in_valid[id] = 1'b1; in_data[id] = 32'hDEAD_BEEF; out_ready[id] = 1'b1;
    end
    step();
    for (int id = 0; id < 2; id++) begin
      check($sformatf("first%0d_valid", id), 32'(out_valid[id]), 32'd1);
      check($sformatf("first%0d_data", id), out_data[id], 32'hDEAD_BEEF);
      check($sformatf("first%0d_in_ready", id), 32'(in_ready[id]), 32'd1);
      in_valid[id] = 1'b0;
    end
    step(); step();

    // SKID=1 stream 1,2,3 with one back-pressure window.
    in_valid[0] = 1'b1; in_data[0] = 32'd1; out_ready[0] = 1'b1;
    step();
    in_data[0] = 32'd2; out_ready[0] = 1'b0;
    step();
    check("sk_hold1_data", out_data[0], 32'd1);
    check("sk_skid_full", 32'(in_ready[0]), 32'd0);
    in_data[0] = 32'd3;
    step();
    check("sk_still1", out_data[0], 32'd1);
    check("sk_still_blocked", 32'(in_ready[0]), 32'd0);
    out_ready[0] = 1'b1;
    step();
    check("sk_out2", out_data[0], 32'd2);
    check("sk_ready_back", 32'(in_ready[0]), 32'd1);
    step();
    check("sk_out3", out_data[0], 32'd3);
    in_valid[0] = 1'b0;
    step();
    check("sk_drained", 32'(out_valid[0]), 32'd0);
    check("sk_stall2", 32'(stall_cnt[0]), 32'd2);

    // SKID=0 stream: in_ready falls combinationally with out_ready.
    in_valid[1] = 1'b1; in_data[1] = 32'd1; out_ready[1] = 1'b1;
    step();
    in_data[1] = 32'd2; out_ready[1] = 1'b0;
    #1;
    check("ns_ready_comb", 32'(in_ready[1]), 32'd0);
    step();
    check("ns_hold1", out_data[1], 32'd1);
    out_ready[1] = 1'b1;
    #1;
    check("ns_ready_rise", 32'(in_ready[1]), 32'd1);
    step();
    check("ns_out2", out_data[1], 32'd2);
    in_data[1] = 32'd3;
    step();
    check("ns_out3", out_data[1], 32'd3);
    in_valid[1] = 1'b0;
    step();
    check("ns_drained", 32'(out_valid[1]), 32'd0);
    check("ns_stall1", 32'(stall_cnt[1]), 32'd1);

    // Flush while in SKID state with a bundle offered.
    in_valid[0] = 1'b1; in_data[0] = 32'd5; out_ready[0] = 1'b1;
    step();
    in_data[0] = 32'd6; out_ready[0] = 1'b0;
    step();
    check("fl_in_skid", 32'(in_ready[0]), 32'd0);
    flush[0] = 1'b1; in_data[0] = 32'd7;
    step();
    flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    check("fl_valid0", 32'(out_valid[0]), 32'd0);
    check("fl_data_nop", out_data[0], 32'd0);
    check("fl_ready1", 32'(in_ready[0]), 32'd1);
    step(); step();
    check("fl_no_7", 32'(out_valid[0]), 32'd0);

    // Flush on SKID=0 drops a same-cycle accept.
    in_valid[1] = 1'b1; in_data[1] = 32'd8; out_ready[1] = 1'b1;
    step();
    in_data[1] = 32'd9; flush[1] = 1'b1;
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    check("fl0_valid0", 32'(out_valid[1]), 32'd0);
    check("fl0_data_nop", out_data[1], 32'd0);
    step();
    check("fl0_no_9", 32'(out_valid[1]), 32'd0);

    // Random traffic on both modes; the model checks order every cycle.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int id = 0; id < 2; id++) begin
        in_valid[id]  = ($urandom_range(0, 99) < 60);
        in_data[id]   = seq[id];
        seq[id]       = seq[id] + 1;
        out_ready[id] = ($urandom_range(0, 99) < 65);
        flush[id]     = ($urandom_range(0, 299) == 0);
      end
      step();
    end
    for (int id = 0; id < 2; id++) begin
      in_valid[id] = 1'b0; out_ready[id] = 1'b1; flush[id] = 1'b0;
    end
    repeat (4) step();
    for (int id = 0; id < 2; id++)
      check($sformatf("rnd%0d_drained", id), 32'(out_valid[id]), 32'd0);

    for (int i = 0; i < 80000 && !sat_done; i++) step();
    check("sat_finished", 32'(sat_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS pipeline, replacing the fixed per-boundary register banks (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width bundle of stage fields under a valid/ready handshake and supports flush (bubble insertion). An optional two-entry skid buffer gives a registered `in_ready`. A saturating stall counter supports performance analysis.

## Interface
- `WIDTH`, 32: bundle width in bits (concatenated stage fields, e.g. Instr/ALU/DM/EXT/PC8/WBA = 165).
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `CNT_W`, 16: stall counter width.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous; discards all held and incoming data.
- `in_valid` in 1: upstream stage presents a bundle.
- `in_ready` out 1: this register accepts a bundle this cycle.
- `in_data` in WIDTH: upstream bundle.
- `out_valid` out 1: `out_data` holds a live bundle.
- `out_ready` in 1: downstream stage consumes this cycle.
- `out_data` out WIDTH: held bundle; driven from the main register only.
- `stall_cnt` out CNT_W: cycles with `out_valid & !out_ready`, saturating.

## Operation
- Accept = `in_valid & in_ready`; consume = `out_valid & out_ready`.
- States (SKID=1): EMPTY, FULL (main only), SKID (main+skid).
  - EMPTY: accept → main<=in_data, FULL.
  - FULL: accept & consume → main<=in_data, stay FULL; accept & no consume → skid<=in_data, SKID; consume only → EMPTY; neither → hold.
  - SKID: consume → main<=skid, FULL; else hold. No accept possible.
- `in_ready` (SKID=1) = state != SKID, taken from a flop.
- SKID=0: states EMPTY/FULL only. `in_ready = !out_valid | out_ready`, combinational. Accept loads main.
- `out_valid` = state != EMPTY.
- Priority: `rst` > `flush` > handshake.
- `flush`: state→EMPTY and main/skid→0 (MIPS NOP). A same-cycle accept is dropped. `stall_cnt` is unaffected.
- `rst`: identical to `flush`, and additionally clears `stall_cnt`.
- `stall_cnt` increments when `out_valid & !out_ready`. It holds at 2^CNT_W−1 and does not wrap.
- Data is never modified, reordered or duplicated; each accepted bundle is consumed exactly once unless flushed.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `stall_cnt`=0, `in_ready`=1 (both modes).
- Latency: bundle accepted at edge N is on `out_data` with `out_valid`=1 after edge N.
- Throughput: one bundle per cycle while `out_ready`=1.
- SKID=1 bubble-free: one back-pressure cycle absorbs one extra bundle, then `in_ready` drops the following cycle.
- Flush takes effect at the edge: `out_valid`=0 from the next cycle; `in_ready`=1 from the next cycle.
- Reset or flush during SKID state: both entries are lost.

## Structure
- Shared package `pipe_pkg`:
  - `pipe_state_t` enum {ST_EMPTY, ST_FULL, ST_SKID}.
  - `NOP_INSTR` = 32'h0000_0000, used as the flush fill value.
- Sub-module `sat_counter` (parameter CNT_W; ports clk, rst, inc, count) for the stall counter.
- Skid logic is generated under `if (SKID)`; the SKID=0 path contains no skid register.

## Test plan
- Reset, then `in_valid`=1, `in_data`=32'hDEADBEEF, `out_ready`=1 → next cycle `out_valid`=1, `out_data`=32'hDEADBEEF, `in_ready`=1.
- SKID=1: stream 1,2,3 with `out_ready`=0 from cycle 2 → 1 on output, 2 in skid, `in_ready`=0, 3 held upstream. Release `out_ready` → outputs 1,2,3 in order, no loss or duplication.
- SKID=0: same stream → `in_ready` falls in the same cycle `out_ready` falls; output order 1,2,3.
- `flush` in SKID state with `in_valid`=1, `in_data`=7 → next cycle `out_valid`=0, `out_data`=0, 7 never appears, `in_ready`=1.
- Hold `out_valid`=1, `out_ready`=0 for 70000 cycles with CNT_W=16 → `stall_cnt`=65535 and stays. `rst` → 0; `flush` leaves it unchanged.
- Random `in_valid`/`out_ready` over 10k cycles, both SKID values → scoreboard shows in-order, exactly-once delivery.
